// File: rtl/uart_pkg.sv
// Shared constants for the UART SFR controller: SCON bit positions,
// default SFR addresses and the RX handshake state encoding.
package uart_pkg;

    localparam int RI_BIT  = 0;
    localparam int TI_BIT  = 1;
    localparam int OVR_BIT = 2;
    localparam int REN_BIT = 4;

    localparam logic [7:0] SBUF_ADDR_DEFAULT = 8'h99;
    localparam logic [7:0] SCON_ADDR_DEFAULT = 8'h98;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/uart_txq.sv
// Synchronous byte FIFO feeding the UART transmitter. A pop on an empty
// queue is ignored; a push on a full queue is accepted only if a pop frees a slot.
module uart_txq #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [7:0]                 i_din,
    input  logic                       i_pop,
    output logic [7:0]                 o_dout,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    logic w_popEff;
    logic w_pushEff;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign w_popEff  = i_pop & ~o_empty;
    assign w_pushEff = i_push & (~o_full | w_popEff);
    assign o_dout    = o_empty ? 8'h00 : r_mem[r_rdPtr];

    always_ff @(posedge i_clk) begin
        if (w_pushEff) begin
            r_mem[r_wrPtr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushEff) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_popEff) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_pushEff, w_popEff})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_sfr_ctrl.sv
// CPU-side UART controller: SBUF/SCON in SFR space, TX byte queue,
// RX capture with interrupt-acknowledge handshake and serial interrupt request.
module uart_sfr_ctrl
    import uart_pkg::*;
#(
    parameter int         TXQ_DEPTH = 4,
    parameter logic [7:0] SBUF_ADDR = SBUF_ADDR_DEFAULT,
    parameter logic [7:0] SCON_ADDR = SCON_ADDR_DEFAULT
) (
    input  logic       i_clk_uart,
    input  logic       i_rst,
    input  logic [7:0] i_sfr_addr,
    input  logic [7:0] i_sfr_wdata,
    input  logic       i_sfr_we,
    input  logic       i_sfr_re,
    output logic [7:0] o_sfr_rdata,
    output logic       o_sfr_hit,
    output logic [7:0] o_tx_data,
    output logic       o_tx_empty,
    input  logic       i_tx_rd_en,
    output logic       o_tx_ovf,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic       o_rx_ack,
    input  logic       i_ser_ie,
    output logic       o_int_req
);

    localparam int CNT_W = $clog2(TXQ_DEPTH) + 1;

    rx_state_e r_rxState;
    rx_state_e w_rxNext;

    logic [7:0] r_scon;
    logic [7:0] r_rxBuf;
    logic       r_rxAck;
    logic [7:0] r_sfrRdata;
    logic       r_sfrHit;
    logic       r_txOvf;
    logic       r_intReq;

    logic [7:0]       w_sconNext;
    logic [7:0]       w_rdData;
    logic             w_rdHit;
    logic             w_capture;
    logic             w_overrun;
    logic             w_sbufWr;
    logic             w_sconWr;
    logic             w_txEmpty;
    logic             w_txFull;
    logic [CNT_W-1:0] w_txCount;
    logic             w_popEff;
    logic             w_drop;
    logic             w_tiSet;

    assign w_sbufWr = i_sfr_we & (i_sfr_addr == SBUF_ADDR);
    assign w_sconWr = i_sfr_we & (i_sfr_addr == SCON_ADDR);
    assign w_popEff = i_tx_rd_en & ~w_txEmpty;
    assign w_drop   = w_sbufWr & w_txFull & ~w_popEff;
    assign w_tiSet  = w_popEff & (w_txCount == CNT_W'(1)) & ~w_sbufWr;

    uart_txq #(
        .DEPTH (TXQ_DEPTH)
    ) u_txq (
        .i_clk   (i_clk_uart),
        .i_rst   (i_rst),
        .i_push  (w_sbufWr),
        .i_din   (i_sfr_wdata),
        .i_pop   (i_tx_rd_en),
        .o_dout  (o_tx_data),
        .o_empty (w_txEmpty),
        .o_full  (w_txFull),
        .o_count (w_txCount)
    );

    always_ff @(posedge i_clk_uart) begin
        if (i_rst) begin
            r_rxState <= IDLE;
        end else begin
            r_rxState <= w_rxNext;
        end
    end

    // A byte is taken only on the IDLE->ACK edge, so a held rx_valid captures once.
    always_comb begin
        w_rxNext  = r_rxState;
        w_capture = 1'b0;
        w_overrun = 1'b0;
        case (r_rxState)
            IDLE: begin
                if (i_rx_valid) begin
                    w_rxNext = ACK;
                    if (r_scon[REN_BIT]) begin
                        w_capture = ~r_scon[RI_BIT];
                        w_overrun = r_scon[RI_BIT];
                    end
                end
            end
            ACK: begin
                if (!i_rx_valid) begin
                    w_rxNext = IDLE;
                end
            end
            default: w_rxNext = IDLE;
        endcase
    end

    // Software may only clear the flag bits; hardware sets override a clear.
    always_comb begin
        w_sconNext = r_scon;
        if (w_sconWr) begin
            w_sconNext = {i_sfr_wdata[7:3], r_scon[2:0] & i_sfr_wdata[2:0]};
        end
        if (w_capture) begin
            w_sconNext[RI_BIT] = 1'b1;
        end
        if (w_overrun) begin
            w_sconNext[OVR_BIT] = 1'b1;
        end
        if (w_tiSet) begin
            w_sconNext[TI_BIT] = 1'b1;
        end
    end

    always_comb begin
        w_rdData = 8'h00;
        w_rdHit  = 1'b0;
        if (i_sfr_re) begin
            if (i_sfr_addr == SBUF_ADDR) begin
                w_rdData = r_rxBuf;
                w_rdHit  = 1'b1;
            end else if (i_sfr_addr == SCON_ADDR) begin
                w_rdData = r_scon;
                w_rdHit  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_uart) begin
        if (i_rst) begin
            r_scon     <= 8'h00;
            r_rxBuf    <= 8'h00;
            r_rxAck    <= 1'b0;
            r_sfrRdata <= 8'h00;
            r_sfrHit   <= 1'b0;
            r_txOvf    <= 1'b0;
            r_intReq   <= 1'b0;
        end else begin
            r_scon     <= w_sconNext;
            if (w_capture) begin
                r_rxBuf <= i_rx_data;
            end
            r_rxAck    <= (w_rxNext == ACK);
            r_sfrRdata <= w_rdData;
            r_sfrHit   <= w_rdHit;
            r_txOvf    <= w_drop;
            r_intReq   <= i_ser_ie & (r_scon[RI_BIT] | r_scon[TI_BIT]);
        end
    end

    assign o_sfr_rdata = r_sfrRdata;
    assign o_sfr_hit   = r_sfrHit;
    assign o_tx_empty  = w_txEmpty;
    assign o_tx_ovf    = r_txOvf;
    assign o_rx_ack    = r_rxAck;
    assign o_int_req   = r_intReq;

endmodule

// File: tb/tb_uart_sfr_ctrl.sv
// Bench for uart_sfr_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_uart_sfr_ctrl;

    localparam int         DEPTH = 4;
    localparam logic [7:0] SBUF  = 8'h99;
    localparam logic [7:0] SCON  = 8'h98;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sfrAddr;
    logic [7:0] sfrWdata;
    logic       sfrWe;
    logic       sfrRe;
    logic [7:0] sfrRdata;
    logic       sfrHit;
    logic [7:0] txData;
    logic       txEmpty;
    logic       txRdEn;
    logic       txOvf;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxAck;
    logic       serIe;
    logic       intReq;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] mQ[$];
    logic [7:0] mScon;
    logic [7:0] mRxBuf;
    logic [7:0] mRdata;
    logic       mBusy;
    logic       mHit;
    logic       mOvf;
    logic       mInt;

    always #5 clk = ~clk;

    uart_sfr_ctrl #(
        .TXQ_DEPTH (DEPTH),
        .SBUF_ADDR (SBUF),
        .SCON_ADDR (SCON)
    ) dut (
        .i_clk_uart  (clk),
        .i_rst       (rst),
        .i_sfr_addr  (sfrAddr),
        .i_sfr_wdata (sfrWdata),
        .i_sfr_we    (sfrWe),
        .i_sfr_re    (sfrRe),
        .o_sfr_rdata (sfrRdata),
        .o_sfr_hit   (sfrHit),
        .o_tx_data   (txData),
        .o_tx_empty  (txEmpty),
        .i_tx_rd_en  (txRdEn),
        .o_tx_ovf    (txOvf),
        .i_rx_data   (rxData),
        .i_rx_valid  (rxValid),
        .o_rx_ack    (rxAck),
        .i_ser_ie    (serIe),
        .o_int_req   (intReq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic re, input logic [7:0] addr,
                                 input logic [7:0] wdata, input logic rdEn);
        sfrWe    = we;
        sfrRe    = re;
        sfrAddr  = addr;
        sfrWdata = wdata;
        txRdEn   = rdEn;
    endtask

    // Advances the model by one clock using the inputs present before the edge.
    task automatic modelStep();
        logic push, pop, newOvf, tiSet, riSet, ovrSet, newHit, newInt;
        logic [7:0] newRdata;
        if (rst) begin
            mQ.delete();
            mScon = 8'h00; mRxBuf = 8'h00; mRdata = 8'h00;
            mBusy = 1'b0;  mHit = 1'b0;    mOvf = 1'b0;   mInt = 1'b0;
            return;
        end
        push     = sfrWe && (sfrAddr == SBUF);
        pop      = txRdEn && (mQ.size() > 0);
        newOvf   = push && (mQ.size() == DEPTH) && !pop;
        tiSet    = pop && (mQ.size() == 1) && !push;
        newHit   = sfrRe && (sfrAddr == SBUF || sfrAddr == SCON);
        newRdata = !newHit ? 8'h00 : ((sfrAddr == SBUF) ? mRxBuf : mScon);
        newInt   = serIe && (mScon[0] || mScon[1]);
        riSet    = 1'b0;
        ovrSet   = 1'b0;
        if (!mBusy && rxValid) begin
            if (mScon[4]) begin
                if (!mScon[0]) begin
                    mRxBuf = rxData;
                    riSet  = 1'b1;
                end else begin
                    ovrSet = 1'b1;
                end
            end
            mBusy = 1'b1;
        end else if (mBusy && !rxValid) begin
            mBusy = 1'b0;
        end
        if (pop) void'(mQ.pop_front());
        if (push && !newOvf) mQ.push_back(sfrWdata);
        if (sfrWe && sfrAddr == SCON) mScon = {sfrWdata[7:3], mScon[2:0] & sfrWdata[2:0]};
        if (riSet)  mScon[0] = 1'b1;
        if (tiSet)  mScon[1] = 1'b1;
        if (ovrSet) mScon[2] = 1'b1;
        mOvf   = newOvf;
        mHit   = newHit;
        mRdata = newRdata;
        mInt   = newInt;
    endtask

    task automatic cycle();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("tx_empty", txEmpty, mQ.size() == 0);
        checkOutput("tx_data", txData, (mQ.size() > 0) ? mQ[0] : 8'h00);
        checkOutput("tx_ovf", txOvf, mOvf);
        checkOutput("rx_ack", rxAck, mBusy);
        checkOutput("int_req", intReq, mInt);
        checkOutput("sfr_rdata", sfrRdata, mRdata);
        checkOutput("sfr_hit", sfrHit, mHit);
    endtask

    task automatic sfrWrite(input logic [7:0] addr, input logic [7:0] data);
        applyStimulus(1'b1, 1'b0, addr, data, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic sfrRead(input logic [7:0] addr, output logic [7:0] data);
        applyStimulus(1'b0, 1'b1, addr, 8'h00, 1'b0);
        cycle();
        data = sfrRdata;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic popOnce();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] rd;
        int         sel;
        logic [7:0] addr;

        rst = 1'b1; rxValid = 1'b0; rxData = 8'h00; serIe = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        cycle();
        cycle();
        checkOutput("reset_tx_empty", txEmpty, 1'b1);
        checkOutput("reset_tx_data", txData, 8'h00);
        rst = 1'b0;
        cycle();

        // Push three bytes, drain them, observe TI and the interrupt
        sfrWrite(SBUF, 8'h11);
        sfrWrite(SBUF, 8'h22);
        sfrWrite(SBUF, 8'h33);
        checkOutput("txq_head0", txData, 8'h11);
        popOnce();
        checkOutput("txq_head1", txData, 8'h22);
        popOnce();
        checkOutput("txq_head2", txData, 8'h33);
        popOnce();
        checkOutput("txq_drained", txEmpty, 1'b1);
        cycle();
        checkOutput("ti_int_req", intReq, 1'b1);
        sfrRead(SCON, rd);
        checkOutput("scon_ti", rd[1], 1'b1);
        sfrWrite(SCON, 8'h00);

        // Overflow on the fifth write, then push+pop while full
        for (int i = 1; i <= 5; i++) sfrWrite(SBUF, 8'(i));
        checkOutput("ovf_pulse", txOvf, 1'b1);
        cycle();
        checkOutput("ovf_one_cycle", txOvf, 1'b0);
        applyStimulus(1'b1, 1'b0, SBUF, 8'h66, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("full_pushpop_ovf", txOvf, 1'b0);
        checkOutput("full_pushpop_head", txData, 8'h02);
        for (int i = 0; i < 4; i++) popOnce();
        checkOutput("full_drained", txEmpty, 1'b1);
        sfrWrite(SCON, 8'h10);

        // RX capture with rx_valid held five cycles
        rxData = 8'hA5; rxValid = 1'b1;
        cycle();
        checkOutput("rx_ack_rise", rxAck, 1'b1);
        for (int i = 0; i < 4; i++) cycle();
        rxValid = 1'b0;
        cycle();
        checkOutput("rx_ack_fall", rxAck, 1'b0);
        sfrRead(SBUF, rd);
        checkOutput("sbuf_a5", rd, 8'hA5);

        // Overrun while RI still set
        rxData = 8'h5A; rxValid = 1'b1;
        cycle(); cycle();
        rxValid = 1'b0;
        cycle(); cycle();
        sfrRead(SBUF, rd);
        checkOutput("sbuf_kept", rd, 8'hA5);
        sfrRead(SCON, rd);
        checkOutput("scon_ovr", rd, 8'h15);
        sfrWrite(SCON, 8'h10);
        sfrRead(SCON, rd);
        checkOutput("scon_cleared", rd, 8'h10);

        // Receiver disabled
        sfrWrite(SCON, 8'h00);
        rxData = 8'hFF; rxValid = 1'b1;
        cycle();
        checkOutput("ren0_ack", rxAck, 1'b1);
        rxValid = 1'b0;
        cycle(); cycle();
        sfrRead(SBUF, rd);
        checkOutput("ren0_sbuf", rd, 8'hA5);
        sfrRead(SCON, rd);
        checkOutput("ren0_ri", rd[0], 1'b0);

        // Software clear of RI colliding with a hardware set
        sfrWrite(SCON, 8'h10);
        rxData = 8'h3C; rxValid = 1'b1;
        applyStimulus(1'b1, 1'b0, SCON, 8'h10, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        rxValid = 1'b0;
        cycle(); cycle();
        sfrRead(SCON, rd);
        checkOutput("ri_set_wins", rd, 8'h11);

        // Reset while in ACK with two bytes queued
        sfrWrite(SBUF, 8'hC1);
        sfrWrite(SBUF, 8'hC2);
        rxValid = 1'b1;
        cycle();
        rst = 1'b1; rxValid = 1'b0;
        cycle();
        checkOutput("midrst_empty", txEmpty, 1'b1);
        checkOutput("midrst_ack", rxAck, 1'b0);
        checkOutput("midrst_int", intReq, 1'b0);
        rst = 1'b0;
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            sel  = $urandom_range(0, 3);
            addr = (sel < 2) ? SBUF : ((sel == 2) ? SCON : 8'($urandom));
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, addr,
                          8'($urandom), $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) rxValid = ~rxValid;
            rxData = 8'($urandom);
            serIe  = ($urandom_range(0, 7) != 0);
            rst    = ($urandom_range(0, 149) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
